wb_dffram_ctrl: RTL and testbench
=================================

Name: wb_dffram_ctrl

Overview:
- Pipelined Wishbone slave that fronts one DFFRAM word-addressed SRAM macro with 32-bit data and 4 byte lanes.
- Converts bus requests into the macro's EN/WE/A/Di strobes and returns the macro's registered Do as read data, with single-cycle ack latency.
- Sits directly upstream of the RAM macro; the core's or SoC's Wishbone interconnect drives it.

Parameters:
- COLS, 1, number of 256-word columns in the attached macro. Depth is 256*COLS words.
- A_WIDTH, 8+$clog2(COLS), word address width. Derived localparam; not overridable.

Ports:
- clk  in  1  system clock; macro shares it.
- rst  in  1  reset, synchronous active-high.
- wb_cyc  in  1  bus cycle.
- wb_stb  in  1  request strobe.
- wb_we  in  1  write request.
- wb_sel  in  4  byte lane selects.
- wb_adr  in  A_WIDTH  word address, already decoded to this slave.
- wb_dat_w  in  32  write data.
- wb_dat_r  out  32  read data.
- wb_ack  out  1  request completion.
- wb_stall  out  1  request not accepted this cycle.
- ram_en  out  1  macro EN.
- ram_we  out  4  macro byte write enables.
- ram_a  out  A_WIDTH  macro address.
- ram_di  out  32  macro write data.
- ram_do  in  32  macro read data. Registered in the macro; forced to 0 on any cycle after EN was low.

Behaviour:
- Accept condition: accept = wb_cyc & wb_stb & ~wb_stall. At most one request accepted per cycle.
- Request path is combinational, with no added latency:
  - ram_en = accept.
  - ram_we = accept & wb_we ? wb_sel : 4'b0.
  - ram_a = wb_adr.
  - ram_di = wb_dat_w.
- Pipeline tracking: registers p_valid and p_we capture accept and wb_we at every clk edge.
- wb_ack = p_valid & wb_cyc. Ack fires exactly 1 cycle after acceptance. Back-to-back requests produce back-to-back acks.
- wb_dat_r = (p_valid & ~p_we) ? ram_do : 32'b0.
  - Read data is the pre-write word; the macro reads before it writes.
  - Write acks return 0.
- Write with wb_sel=0: accepted and acked; memory unchanged.
- wb_cyc dropped while p_valid=1: ack suppressed. p_valid clears at the next edge. A write already issued to the macro still completes.
- wb_stb high with wb_cyc low: ignored; ram_en=0.
- Address beyond the macro depth cannot occur, because the width equals A_WIDTH.
- wb_stall = 0 in normal operation; see Optional Feature.
- Reset (rst=1 at an edge):
  - p_valid=0 and p_we=0, so wb_ack=0 and wb_dat_r=0 on the next cycle.
  - During the rst cycle, ram_en=0 and ram_we=0 regardless of bus inputs.
  - A request accepted in the cycle before reset is not acked.
- Reset does not alter RAM contents; macro preload image is preserved.

Optional Feature:
- Macro: DFFRAM_CTRL_CLEAR_EN.
- Defined: an FSM with states CLEAR and READY.
  - Reset enters CLEAR with the clear counter at 0.
  - In CLEAR:
    - wb_stall=1.
    - ram_en=1, ram_we=4'hF, ram_di=0, ram_a=counter.
    - Counter increments each cycle.
  - After writing address 256*COLS-1, the FSM moves to READY; wb_stall=0 from that cycle.
  - Clear takes exactly 256*COLS cycles after reset deassertion.
  - rst mid-clear restarts at address 0.
  - No acks are generated during CLEAR.
- Undefined: no FSM; wb_stall is tied 0 and RAM keeps its preload image across reset.

Test Plan:
- Write then read: write adr 0x12, data 0xDEADBEEF, sel 0xF; read adr 0x12 -> ack 1 cycle after each stb; read wb_dat_r=0xDEADBEEF; write ack wb_dat_r=0.
- Byte lanes: preload 0x11223344 at adr 5; write 0xAABBCCDD with sel 0x5; read adr 5 -> 0x11BB33DD.
- Pipelined burst: reads of adr 0,1,2,3 on consecutive cycles, preloaded 0xA0..0xA3 -> 4 consecutive acks with data 0xA0, 0xA1, 0xA2, 0xA3; wb_stall=0 throughout.
- Read-after-write same address back-to-back: write 0x55 to adr 7 (old 0x99), then read adr 7 next cycle -> read returns 0x55; a read issued in the same cycle as the write would not be possible.
- Abort and reset: accept read, drop wb_cyc next cycle -> no ack. Accept read, assert rst next cycle -> no ack, wb_dat_r=0. Preloaded contents intact afterwards.
- With DFFRAM_CTRL_CLEAR_EN, COLS=1:
  - After rst, wb_stall=1 for exactly 256 cycles; a stb held during clear is accepted on cycle 257.
  - Reading adr 0xFF returns 0.
  - rst at clear cycle 100 restarts the 256-cycle count.

Source files
------------

// File: rtl/wb_dffram_ctrl.sv
`default_nettype none
// wb_dffram_ctrl: pipelined Wishbone slave for a DFFRAM macro, single-cycle ack. Rev 1.0
// Define DFFRAM_CTRL_CLEAR_EN to zero the whole macro after every reset.
module wb_dffram_ctrl #(
   parameter int COLS = 1,
   localparam int A_WIDTH = 8 + $clog2(COLS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_cyc,
   input  logic               wb_stb,
   input  logic               wb_we,
   input  logic [3:0]         wb_sel,
   input  logic [A_WIDTH-1:0] wb_adr,
   input  logic [31:0]        wb_dat_w,
   output logic [31:0]        wb_dat_r,
   output logic               wb_ack,
   output logic               wb_stall,
   output logic               ram_en,
   output logic [3:0]         ram_we,
   output logic [A_WIDTH-1:0] ram_a,
   output logic [31:0]        ram_di,
   input  logic [31:0]        ram_do
);

   logic               accept;
   logic               clearing;
   logic [A_WIDTH-1:0] clr_a;
   logic               p_valid_q, p_valid_d;
   logic               p_we_q, p_we_d;

`ifdef DFFRAM_CTRL_CLEAR_EN
   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_READY = 1'b1;
   localparam int         DEPTH   = 256 * COLS;

   logic [0:0]         state_q, state_d;
   logic [A_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_CLEAR) begin
         cnt_d = cnt_q + A_WIDTH'(1);
         if (cnt_q == A_WIDTH'(DEPTH - 1)) begin
            state_d = S_READY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobes are held off during the reset cycle itself even if the FSM already sits in CLEAR.
   assign clearing = (state_q == S_CLEAR) & ~rst;
   assign clr_a    = cnt_q;
   assign wb_stall = (state_q == S_CLEAR);
`else
   assign clearing = 1'b0;
   assign clr_a    = '0;
   assign wb_stall = 1'b0;
`endif

   assign accept = wb_cyc & wb_stb & ~wb_stall & ~rst;

   assign ram_en = accept | clearing;
   assign ram_we = clearing ? 4'hF : ((accept & wb_we) ? wb_sel : 4'h0);
   assign ram_a  = clearing ? clr_a : wb_adr;
   assign ram_di = clearing ? 32'h0 : wb_dat_w;

   assign p_valid_d = accept;
   assign p_we_d    = wb_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_valid_q <= 1'b0;
         p_we_q    <= 1'b0;
      end else begin
         p_valid_q <= p_valid_d;
         p_we_q    <= p_we_d;
      end
   end

   // A request accepted just before reset must not be acked while rst is high.
   assign wb_ack   = p_valid_q & wb_cyc & ~rst;
   assign wb_dat_r = (p_valid_q & ~p_we_q & ~rst) ? ram_do : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_wb_dffram_ctrl.sv
`default_nettype none
// tb_wb_dffram_ctrl: randomized scoreboard bench for wb_dffram_ctrl with a behavioural DFFRAM macro.
module tb_wb_dffram_ctrl;

   localparam int COLS  = 1;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_cyc, wb_stb, wb_we;
   logic [3:0]    wb_sel;
   logic [AW-1:0] wb_adr;
   logic [31:0]   wb_dat_w, wb_dat_r;
   logic          wb_ack, wb_stall;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_a;
   logic [31:0]   ram_di, ram_do;

   always #5 clk = ~clk;

   wb_dffram_ctrl #(.COLS(COLS)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc   (wb_cyc),
      .wb_stb   (wb_stb),
      .wb_we    (wb_we),
      .wb_sel   (wb_sel),
      .wb_adr   (wb_adr),
      .wb_dat_w (wb_dat_w),
      .wb_dat_r (wb_dat_r),
      .wb_ack   (wb_ack),
      .wb_stall (wb_stall),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_a    (ram_a),
      .ram_di   (ram_di),
      .ram_do   (ram_do)
   );

   // Macro model: read-before-write, registered Do, Do forced to 0 after an idle cycle.
   logic [31:0]   mem [DEPTH];
   logic          pre_en;
   logic [AW-1:0] pre_a;
   logic [31:0]   pre_d;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_a] <= pre_d;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
         end
      end
      ram_do <= ram_en ? mem[ram_a] : 32'h0;
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt++;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ref_mem [DEPTH];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   task automatic req(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
      int   waited;
      exp_t e;
      waited   = 0;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = we;
      wb_adr   = adr;
      wb_dat_w = dat;
      wb_sel   = sel;
      #1;
      while (wb_stall && waited < 1000) begin
         @(posedge clk); #1;
         waited++;
      end
      if (wb_stall) begin
         n_vec++;
         n_err++;
         $display("FAIL stall_timeout: stall still 1 after %0d cycles, expected 0", waited);
      end else begin
         check("ram_en", {31'h0, ram_en}, 32'h1);
         check("ram_we", {28'h0, ram_we}, we ? {28'h0, sel} : 32'h0);
         check("ram_a", {24'h0, ram_a}, {24'h0, adr});
         check("ram_di", ram_di, dat);
         e.due  = cyc_cnt + 1;
         e.data = we ? 32'h0 : ref_mem[adr];
         sb_q.push_back(e);
         if (we) ref_mem[adr] = merge(ref_mem[adr], dat, sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      wb_cyc = 1'b1;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

`ifdef DFFRAM_CTRL_CLEAR_EN
   task automatic count_clear(output int n, output int bad);
      n   = 0;
      bad = 0;
      while (wb_stall && n < 1000) begin
         if (ram_en !== 1'b1 || ram_we !== 4'hF || ram_a !== AW'(n) || ram_di !== 32'h0) bad++;
         if (wb_ack !== 1'b0) bad++;
         n++;
         @(posedge clk); #1;
      end
   endtask
`endif

   // Leaves a read of 0xFF on the bus so the caller's req() shows when it is first accepted.
   task automatic do_reset();
      int n, bad;
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = 1'b0;
      wb_sel = 4'hF;
      wb_adr = 8'hFF;
      rst    = 1'b1;
      #1;
      check("rst_ack", {31'h0, wb_ack}, 32'h0);
      check("rst_dat_r", wb_dat_r, 32'h0);
      check("rst_ram_en", {31'h0, ram_en}, 32'h0);
      check("rst_ram_we", {28'h0, ram_we}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst_ack", {31'h0, wb_ack}, 32'h0);
      check("post_rst_dat_r", wb_dat_r, 32'h0);
`ifdef DFFRAM_CTRL_CLEAR_EN
      count_clear(n, bad);
      check("clear_len", n, 256);
      check("clear_strobes", bad, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
`else
      n   = 0;
      bad = 0;
      check("stall_idle", {31'h0, wb_stall}, 32'h0);
`endif
   endtask

   initial begin
      exp_t  e;
      logic  rw;
      logic [AW-1:0] ra;

      rst      = 1'b1;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = 1'b1;
      wb_sel   = 4'hF;
      wb_adr   = 8'h33;
      wb_dat_w = 32'hFFFF_FFFF;
      pre_en   = 1'b0;
      pre_a    = '0;
      pre_d    = '0;

      fork
         forever begin
            @(negedge clk);
            while (sb_q.size() != 0 && sb_q[0].due < cyc_cnt) begin
               n_vec++;
               n_err++;
               $display("FAIL missing_ack: no ack in cycle %0d, expected data %h",
                        sb_q[0].due, sb_q[0].data);
               void'(sb_q.pop_front());
            end
            if (wb_ack === 1'b1) begin
               if (sb_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_ack: ack=1 in cycle %0d, expected ack=0", cyc_cnt);
               end else begin
                  e = sb_q.pop_front();
                  check("ack_cycle", cyc_cnt, e.due);
                  check("rdata", wb_dat_r, e.data);
               end
            end
         end
         begin
            #2ms;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      @(posedge clk); #1;
      check("init_ram_en", {31'h0, ram_en}, 32'h0);
      check("init_ram_we", {28'h0, ram_we}, 32'h0);
      check("init_ack", {31'h0, wb_ack}, 32'h0);
      check("init_dat_r", wb_dat_r, 32'h0);
      for (int i = 0; i < DEPTH; i++) begin
         pre_en     = 1'b1;
         pre_a      = AW'(i);
         pre_d      = $urandom;
         ref_mem[i] = pre_d;
         @(posedge clk); #1;
      end
      pre_en = 1'b0;

      // Default build reads the preload image; clear build reads 0 on the 257th cycle.
      do_reset();
      req(1'b0, 8'hFF, 32'h0, 4'hF);
      idle(1);

      req(1'b1, 8'h12, 32'hDEAD_BEEF, 4'hF);
      req(1'b0, 8'h12, 32'h0, 4'hF);
      idle(1);

      req(1'b1, 8'h05, 32'h1122_3344, 4'hF);
      req(1'b1, 8'h05, 32'hAABB_CCDD, 4'h5);
      req(1'b0, 8'h05, 32'h0, 4'hF);
      idle(1);
      check("byte_lane_model", ref_mem[5], 32'h11BB_33DD);

      for (int i = 0; i < 4; i++) req(1'b1, AW'(i), 32'hA0 + i, 4'hF);
      idle(1);
      for (int i = 0; i < 4; i++) begin
         check("burst_stall", {31'h0, wb_stall}, 32'h0);
         req(1'b0, AW'(i), 32'h0, 4'hF);
      end
      idle(1);

      req(1'b1, 8'h07, 32'h99, 4'hF);
      req(1'b1, 8'h07, 32'h55, 4'hF);
      req(1'b0, 8'h07, 32'h0, 4'hF);
      req(1'b1, 8'h08, 32'h1234_5678, 4'h0);
      req(1'b0, 8'h08, 32'h0, 4'hF);
      idle(2);

      // Accepted read followed by wb_cyc drop: no ack.
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 8'h20;
      @(posedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      #1;
      check("abort_ack", {31'h0, wb_ack}, 32'h0);
      check("abort_ram_en", {31'h0, ram_en}, 32'h0);
      @(posedge clk); #1;

      // Aborted write still lands in the macro.
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 8'h40;
      wb_dat_w = 32'hCAFE_F00D; wb_sel = 4'hF;
      ref_mem[8'h40] = 32'hCAFE_F00D;
      @(posedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;
      wb_stb = 1'b1; wb_cyc = 1'b0;
      #1;
      check("stb_no_cyc_ram_en", {31'h0, ram_en}, 32'h0);
      @(posedge clk); #1;
      req(1'b0, 8'h40, 32'h0, 4'hF);
      idle(1);

      // Accepted read followed by reset: no ack, contents kept (or cleared in clear build).
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 8'h21;
      @(posedge clk); #1;
      do_reset();
      req(1'b0, 8'hFF, 32'h0, 4'hF);
      req(1'b0, 8'h80, 32'h0, 4'hF);
      req(1'b0, 8'h40, 32'h0, 4'hF);
      idle(1);

`ifdef DFFRAM_CTRL_CLEAR_EN
      wb_stb = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
      end
      check("mid_clear_stall", {31'h0, wb_stall}, 32'h1);
      do_reset();
      req(1'b0, 8'hFF, 32'h0, 4'hF);
      idle(1);
`endif

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) begin
            idle(1);
         end else begin
            rw = 1'($urandom_range(1));
            ra = ($urandom_range(1) == 0) ? AW'($urandom_range(15)) : AW'($urandom);
            req(rw, ra, $urandom, 4'($urandom));
         end
      end
      idle(3);
      check("sb_drained", sb_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
